uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte sources.
- Arbitrates requests, latches the winner's byte, and drives the transmitter's data_ready/data_in handshake.
- Tracks frame occupancy by counting baud ticks, because the transmitter has no busy output.
- Sits between the requester blocks and the UART transmitter; both run on the same clk and baud_tick.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; must match the transmitter.
- GAP_TICKS, 0, extra idle baud ticks inserted after each stop bit (0..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- baud_tick  input  1  one-clk strobe shared with the transmitter.
- req  input  NUM_REQ  per-requester send request; held until ack.
- req_data  input  NUM_REQ*DATA_WIDTH  byte of requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  output  NUM_REQ  one-clk pulse: byte of requester i latched.
- grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester.
- busy  output  1  high from grant until the frame window ends.
- done  output  1  one-clk pulse at the end of each frame window.
- tx_data_ready  output  1  to transmitter data_ready.
- tx_data  output  DATA_WIDTH  to transmitter data_in; stable for the whole frame.

Behaviour:
- Reset: state=IDLE; ack=0; done=0; busy=0; tx_data_ready=0; tx_data=0; grant_id=0; pointer=0; tick counter=0.
- The transmitter shares rst, so a reset mid-frame returns both blocks to idle together; the partial frame is abandoned and not acked again.
- IDLE:
  - If any req bit is set, select a winner (see Optional Feature) and latch req_data[winner] into tx_data.
  - Set grant_id=winner, pulse ack[winner] for one clk, set busy=1 and go to LAUNCH.
  - All of this happens in the same clk edge; ack is registered and high during the next cycle.
  - Requests arriving during busy wait; they are not queued beyond the req level.
- LAUNCH:
  - tx_data_ready=1.
  - On the first clk with baud_tick=1 (the launch tick), the transmitter leaves its idle state.
  - The arbiter drops tx_data_ready on that same edge, clears the counter and goes to FRAME.
  - tx_data_ready is never high for more than one baud_tick, so exactly one frame is sent per grant.
- FRAME:
  - Count baud ticks after the launch tick.
  - On tick number DATA_WIDTH+3+GAP_TICKS: pulse done, clear busy, go to IDLE.
  - This tick is the one at which the transmitter's stop-bit interval ends.
  - With GAP_TICKS=0 a pending request is granted and launched so the next start bit follows the stop bit with no idle tick (back-to-back).
- tx_data holds its value from latch until the next grant; it is not cleared at done.
- ack is one-hot or zero; done and ack never pulse in the same cycle.
- A requester dropping req after ack is legal. Dropping req before ack is also legal: it is simply not granted.
- Counter width is 5 bits, sized for DATA_WIDTH+3+GAP_TICKS ≤ 31.
- baud_tick high for consecutive clks counts each clk as a tick.

Optional Feature:
- Macro: UART_TX_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at (last grant_id + 1) mod NUM_REQ; the pointer updates only on grant.
  - After reset the search starts at index 0.
- Undefined: fixed priority; the lowest asserted index always wins and the pointer logic is removed.

Test Plan:
- Single request, req[2]=1 with byte 0xA5 → one ack[2] pulse and tx_data=0xA5. tx_data_ready is high until the first baud_tick then low. done comes 11 ticks later (DATA_WIDTH=8, GAP_TICKS=0). Transmitter line shows 0, 1,0,1,0,0,1,0,1, parity 0, then 1.
- Contention, req=4'b1111 held, each byte unique → with RR_EN grants are 0,1,2,3,0. Without RR_EN, grants are 0,0,0 while req[0] is held. Frames are back-to-back with no extra idle tick.
- GAP_TICKS=3, two queued requests → the second start bit begins 3 baud ticks after the first stop bit ends; busy is low for exactly one clk between frames.
- req_data changes right after ack → the serialized byte equals the value latched at grant, unaffected by the change.
- rst asserted mid-data-bits → all outputs return to reset values immediately (asynchronously). After release, the pending request is re-granted with a new ack and a complete frame is sent.
- No requests for 100 baud ticks → busy=0, tx_data_ready=0, and no ack or done pulses.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources.
// The block grants one requester, latches its byte and raises tx_data_ready
// until the transmitter launches on a baud tick. The transmitter has no busy
// output, so the block then counts baud ticks to find the end of the frame.
// Build option: define UART_TX_ARB_RR_EN for round-robin arbitration.
// Without it, the lowest asserted request index always wins.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_TICKS  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            baud_tick,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              ack,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            done,
  output logic                            tx_data_ready,
  output logic [DATA_WIDTH-1:0]           tx_data
);

  localparam int IDW = $clog2(NUM_REQ);

  // Ticks after the launch tick: start bit, data bits, parity, stop bit and the idle gap.
  localparam logic [4:0] FRAME_TICKS = 5'(DATA_WIDTH + 3 + GAP_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_FRAME  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [IDW-1:0]          grant_id_q, grant_id_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [4:0]              cnt_q, cnt_d;

  logic [IDW-1:0]          winner;
  logic                    found;

`ifdef UART_TX_ARB_RR_EN
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [IDW:0]            cand;

  // Round-robin search: the first asserted request at or after the pointer wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end
`else
  // Fixed priority: scan downwards so the lowest asserted index is written last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        found  = 1'b1;
        winner = IDW'(k);
      end
    end
  end
`endif

  // Next-state and next-output logic for the grant / launch / frame sequence.
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    done_d     = 1'b0;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
`ifdef UART_TX_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          tx_data_d     = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
          grant_id_d    = winner;
          ack_d[winner] = 1'b1;
          busy_d        = 1'b1;
          ready_d       = 1'b1;
          cnt_d         = '0;
          state_d       = ST_LAUNCH;
`ifdef UART_TX_ARB_RR_EN
          if (winner == IDW'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = winner + 1'b1;
          end
`endif
        end
      end
      ST_LAUNCH: begin
        if (baud_tick) begin
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (baud_tick) begin
          if (cnt_q == FRAME_TICKS - 5'd1) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
`ifdef UART_TX_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
`ifdef UART_TX_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign ack           = ack_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign tx_data_ready = ready_q;
  assign tx_data       = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter.
// Instance dut uses GAP_TICKS=0 and instance dut_gap uses GAP_TICKS=3.
// Baud ticks are random, so consecutive-tick clocks also occur.
module tb_uart_tx_arbiter;

  localparam int NR      = 4;
  localparam int DW      = 8;
  localparam int GAP_B   = 3;
  localparam int FRAME   = DW + 3;
  localparam int FRAME_G = DW + 3 + GAP_B;
  localparam int LIMIT   = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud_tick = 1'b0;
  bit   tick_en = 1'b1;

  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    ack;
  logic [1:0]       grant_id;
  logic             busy, done, tx_data_ready;
  logic [DW-1:0]    tx_data;

  logic [NR-1:0]    req_g = '0;
  logic [NR*DW-1:0] req_data_g = '0;
  logic [NR-1:0]    ack_g;
  logic [1:0]       grant_id_g;
  logic             busy_g, done_g, tx_data_ready_g;
  logic [DW-1:0]    tx_data_g;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  logic [DW-1:0] byte_m [NR];

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GAP_TICKS(0)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .done(done),
    .tx_data_ready(tx_data_ready), .tx_data(tx_data)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GAP_TICKS(GAP_B)) dut_gap (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req_g), .req_data(req_data_g),
    .ack(ack_g), .grant_id(grant_id_g), .busy(busy_g), .done(done_g),
    .tx_data_ready(tx_data_ready_g), .tx_data(tx_data_g)
  );

  always #5 clk = ~clk;

  // Random baud strobe, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      baud_tick = tick_en && ($urandom_range(0, 3) == 0);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference arbitration: which requester should win given the request set.
  function automatic int pick(input logic [NR-1:0] m, input int p);
`ifdef UART_TX_ARB_RR_EN
    for (int k = 0; k < NR; k++) begin
      if (m[(p + k) % NR]) return (p + k) % NR;
    end
`else
    for (int k = 0; k < NR; k++) begin
      if (m[k]) return k;
    end
`endif
    return -1;
  endfunction

  // Follows one frame on dut from grant to done; returns at the done clock.
  task automatic check_frame(input int exp_id, input logic [DW-1:0] exp_byte,
                             input bit drop, input string tag, output int waited);
    logic [NR-1:0] exp_ack;
    bit tick;
    bit ok;
    int guard;
    int ticks;
    exp_ack = '0;
    exp_ack[exp_id] = 1'b1;
    waited = 0;
    while (ack === '0 && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (ack !== exp_ack) begin
      n_fail++;
      $display("[TB] FAIL %s ack: got %b expected %b", tag, ack, exp_ack);
      return;
    end
`ifdef UART_TX_ARB_RR_EN
    ptr_m = (exp_id + 1) % NR;
`endif
    n_checks++;
    if (grant_id !== 2'(exp_id) || tx_data !== exp_byte) begin
      n_fail++;
      $display("[TB] FAIL %s grant: got id %0d data %h expected id %0d data %h",
               tag, grant_id, tx_data, exp_id, exp_byte);
    end
    n_checks++;
    if ({busy, tx_data_ready, done} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL %s grant_flags: got busy/ready/done %b expected 110",
               tag, {busy, tx_data_ready, done});
    end
    if (drop) begin
      req[exp_id] = 1'b0;
      req_data[exp_id*DW +: DW] = ~exp_byte;
    end
    guard = 0;
    ok = 1'b1;
    do begin
      if (tx_data_ready !== 1'b1 || busy !== 1'b1) ok = 1'b0;
      tick = baud_tick;
      @(negedge clk);
      guard++;
    end while (!tick && guard < LIMIT);
    n_checks++;
    if (!ok || tx_data_ready !== 1'b0 || !tick) begin
      n_fail++;
      $display("[TB] FAIL %s launch: ready after launch %b, held ok %0d, launched %0d expected 0/1/1",
               tag, tx_data_ready, ok, tick);
    end
    ticks = 0;
    ok = 1'b1;
    while (ticks < FRAME && guard < LIMIT) begin
      if (done !== 1'b0 || busy !== 1'b1 || tx_data !== exp_byte ||
          tx_data_ready !== 1'b0 || ack !== '0) ok = 1'b0;
      tick = baud_tick;
      @(negedge clk);
      guard++;
      if (tick) ticks++;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL %s in_frame: outputs changed during frame, expected stable busy=1 data=%h",
               tag, exp_byte);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_data !== exp_byte || grant_id !== 2'(exp_id)) begin
      n_fail++;
      $display("[TB] FAIL %s done: got done %b busy %b data %h id %0d after %0d ticks expected 1 0 %h %0d after %0d",
               tag, done, busy, tx_data, grant_id, ticks, exp_byte, exp_id, FRAME);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    req_g = '0;
    req_data_g = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ack, grant_id, busy, done, tx_data_ready, tx_data} !== '0 ||
        {ack_g, grant_id_g, busy_g, done_g, tx_data_ready_g, tx_data_g} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got %h / %h expected 0",
               {ack, grant_id, busy, done, tx_data_ready, tx_data},
               {ack_g, grant_id_g, busy_g, done_g, tx_data_ready_g, tx_data_g});
    end
    rst = 1'b0;
    ptr_m = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ack, busy, done, tx_data_ready} !== '0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got %b expected 0", {ack, busy, done, tx_data_ready});
    end
  endtask

  task automatic test_single;
    int w;
    req_data[2*DW +: DW] = 8'hA5;
    req[2] = 1'b1;
    check_frame(2, 8'hA5, 1'b1, "single", w);
  endtask

  task automatic test_contention;
    int seq [5];
    int w;
    logic [DW-1:0] b;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
`ifdef UART_TX_ARB_RR_EN
    seq = '{0, 1, 2, 3, 0};
`else
    seq = '{0, 0, 0, 0, 0};
`endif
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF;
    for (int f = 0; f < 5; f++) begin
      b = 8'(17 * (seq[f] + 1));
      check_frame(seq[f], b, 1'b0, "contention", w);
      if (f > 0) begin
        n_checks++;
        if (w !== 1) begin
          n_fail++;
          $display("[TB] FAIL back_to_back: grant came %0d clocks after done, expected 1", w);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_random;
    int w;
    int nf;
    int exp_id;
    logic [NR-1:0] nb;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NR; i++) begin
        byte_m[i] = 8'($urandom);
        req_data[i*DW +: DW] = byte_m[i];
      end
      req = 4'($urandom_range(1, 15));
      nf = 0;
      while (req != '0 && nf < 16) begin
        exp_id = pick(req, ptr_m);
        check_frame(exp_id, byte_m[exp_id], 1'b1, "random", w);
        if (nf > 0) begin
          n_checks++;
          if (w !== 1) begin
            n_fail++;
            $display("[TB] FAIL random_back_to_back: grant %0d clocks after done, expected 1", w);
          end
        end
        if ($urandom_range(0, 1) == 1) begin
          nb = 4'($urandom_range(0, 15)) & ~req;
          for (int i = 0; i < NR; i++) begin
            if (nb[i]) begin
              byte_m[i] = 8'($urandom);
              req_data[i*DW +: DW] = byte_m[i];
            end
          end
          req = req | nb;
        end
        nf++;
      end
      req = '0;
    end
  endtask

  task automatic test_reset_mid;
    int w;
    int guard;
    int ticks;
    bit tick;
    req_data[3*DW +: DW] = 8'h3C;
    req[3] = 1'b1;
    guard = 0;
    while (ack === '0 && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    ticks = 0;
    while (ticks < 4 && guard < LIMIT) begin
      tick = baud_tick;
      @(negedge clk);
      guard++;
      if (tick) ticks++;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_frame_busy: got %b expected 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ack, grant_id, busy, done, tx_data_ready, tx_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %h expected 0",
               {ack, grant_id, busy, done, tx_data_ready, tx_data});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    check_frame(3, 8'h3C, 1'b1, "regrant", w);
  endtask

  task automatic test_gap;
    int ids [2];
    logic [DW-1:0] bytes [2];
    logic [NR-1:0] exp_ack;
    int guard;
    int ticks;
    bit tick;
    ids = '{1, 3};
    bytes = '{8'h5A, 8'hC3};
    req_data_g = '0;
    req_data_g[1*DW +: DW] = 8'h5A;
    req_data_g[3*DW +: DW] = 8'hC3;
    req_g = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      exp_ack = '0;
      exp_ack[ids[k]] = 1'b1;
      guard = 0;
      while (ack_g === '0 && guard < LIMIT) begin
        @(negedge clk);
        guard++;
      end
      n_checks++;
      if (ack_g !== exp_ack || tx_data_g !== bytes[k]) begin
        n_fail++;
        $display("[TB] FAIL gap_grant: got ack %b data %h expected %b %h",
                 ack_g, tx_data_g, exp_ack, bytes[k]);
      end
      req_g[ids[k]] = 1'b0;
      do begin
        tick = baud_tick;
        @(negedge clk);
        guard++;
      end while (!tick && guard < LIMIT);
      ticks = 0;
      while (done_g !== 1'b1 && guard < LIMIT) begin
        tick = baud_tick;
        @(negedge clk);
        guard++;
        if (tick) ticks++;
      end
      n_checks++;
      if (ticks != FRAME_G || done_g !== 1'b1 || busy_g !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL gap_len: got %0d ticks done %b busy %b expected %0d ticks done 1 busy 0",
                 ticks, done_g, busy_g, FRAME_G);
      end
      @(negedge clk);
      n_checks++;
      if (busy_g !== (k == 0) || done_g !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL gap_busy_low: got busy %b done %b expected busy %0d done 0",
                 busy_g, done_g, (k == 0));
      end
    end
  endtask

  task automatic test_idle;
    int ticks;
    int guard;
    bit ok;
    bit tick;
    req = '0;
    req_g = '0;
    ticks = 0;
    guard = 0;
    ok = 1'b1;
    while (ticks < 100 && guard < 4000) begin
      if ({ack, busy, done, tx_data_ready} !== '0 ||
          {ack_g, busy_g, done_g, tx_data_ready_g} !== '0) ok = 1'b0;
      tick = baud_tick;
      @(negedge clk);
      guard++;
      if (tick) ticks++;
    end
    n_checks++;
    if (!ok || ticks < 100) begin
      n_fail++;
      $display("[TB] FAIL idle: quiet %0d over %0d ticks, expected quiet 1 over 100 ticks", ok, ticks);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single();
    test_contention();
    test_random();
    test_reset_mid();
    test_gap();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
